// File: rtl/corescore_uart_pkg.sv
// Shared types and constants for the AXI-stream UART transmitter.
package corescore_uart_pkg;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // Buffered byte plus its end-of-message marker
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } tx_entry_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Registered-output byte FIFO: no fall-through, push blocked while full.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  mem [DEPTH];
  logic          push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream to 8N1 UART transmitter with a small byte buffer and
// end-of-message pulse after the stop bit of a tlast byte.
module axis_uart_tx
  import corescore_uart_pkg::*;
#(
  parameter int DIVISOR    = 278,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              o_tready,
  output logic              o_uart_tx,
  output logic              o_busy,
  output logic              o_msg_done
);
  localparam logic [15:0] BAUD_MAX = 16'(DIVISOR - 1);

  tx_entry_t   wr_entry, rd_entry;
  logic        full, empty, push, pop, load;

  tx_state_e         state_q, state_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  assign o_tready   = ~full & i_rst_n;
  assign push       = i_tvalid & o_tready;
  assign wr_entry   = '{last: i_tlast, data: i_tdata};
  assign o_uart_tx  = tx_q;
  assign o_msg_done = done_q;
  assign o_busy     = ~empty | (state_q != IDLE);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty)
  );

  // Line level is registered from the next-state decision, so the start bit
  // appears the cycle after the pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = ~empty;
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          baud_d  = BAUD_MAX;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'(DATA_W - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          done_d = last_q;
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      baud_d  = BAUD_MAX;
      bit_d   = '0;
      shreg_d = rd_entry.data;
      last_d  = rd_entry.last;
      tx_d    = 1'b0;
    end
  end

  assign pop = load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: doc/axis_uart_tx.md
AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 SHALL have parameter DIVISOR, default 278, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte buffer entries; power of two, at least 2.
REQ-003 SHALL have port i_clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port i_tdata, input, 8 bits, AXI-stream byte from the upstream score generator.
REQ-006 SHALL have port i_tlast, input, 1 bit, marks the final byte of a message.
REQ-007 SHALL have port i_tvalid, input, 1 bit, upstream byte valid.
REQ-008 SHALL have port o_tready, output, 1 bit, block can accept a byte.
REQ-009 SHALL have port o_uart_tx, output, 1 bit, 8N1 serial line, idle high.
REQ-010 SHALL have port o_busy, output, 1 bit, high while FIFO non-empty or a frame is in flight.
REQ-011 SHALL have port o_msg_done, output, 1 bit, one-cycle pulse after the stop bit of a tlast byte.

Function
REQ-012 SHALL accept a byte and its tlast into the FIFO on every cycle where i_tvalid and o_tready are both high.
REQ-013 SHALL drive o_tready as NOT FIFO-full, forced low while i_rst_n is low; no push when full, even if a pop occurs the same cycle.
REQ-014 SHALL perform push and pop in the same cycle when not full, leaving occupancy unchanged.
REQ-015 SHALL not fall through: a byte pushed into an empty FIFO becomes poppable the next cycle.
REQ-016 SHALL use transmit FSM states IDLE, START, DATA, STOP.
REQ-017 SHALL pop the FIFO head in IDLE when the FIFO is non-empty and enter START next cycle; from the handshake cycle into an empty idle block, o_uart_tx falls exactly 2 cycles later.
REQ-018 SHALL hold each of START (low), DATA (8 bits, LSB first) and STOP (high) for exactly DIVISOR cycles per bit, using a baud counter counting DIVISOR-1 down to 0 and a 3-bit bit index.
REQ-019 SHALL pop the next byte on the last STOP cycle when the FIFO is non-empty and go directly to START, with no idle gap; back-to-back frame period is exactly 10*DIVISOR cycles.
REQ-020 SHALL otherwise go from STOP to IDLE, with o_uart_tx high.
REQ-021 SHALL register o_uart_tx, with no combinational path from any input.
REQ-022 SHALL pulse o_msg_done high for one cycle, the cycle after the last STOP cycle of a byte whose tlast was 1.
REQ-023 SHALL keep the tlast bit of a popped byte in a register through the frame.
REQ-024 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, with occupancy tracked in log2(FIFO_DEPTH)+1 bits.
REQ-025 SHALL compute o_busy as FIFO non-empty OR state not IDLE.

Reset
REQ-026 SHALL, on i_rst_n low, immediately and asynchronously clear state to IDLE, clear FIFO pointers and occupancy, and clear counters.
REQ-027 SHALL, on i_rst_n low, set o_uart_tx=1, o_tready=0, o_busy=0, o_msg_done=0.
REQ-028 SHALL abort a frame when reset is asserted mid-frame: the line returns high at once, buffered bytes are discarded, and no o_msg_done is issued.
REQ-029 SHALL drive o_tready=1 in the first cycle after i_rst_n rises, and SHALL NOT start a frame until the first handshake.

Structure
REQ-030 SHALL place the FSM state enum, frame bit count (10) and data width (8) in shared package corescore_uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module uart_tx_fifo with push, pop, full, empty and a 9-bit data path; FSM and baud logic stay in axis_uart_tx.

Verification (DIVISOR=4, FIFO_DEPTH=4)
REQ-032 Single byte 0x55, tlast=0, into idle block: o_uart_tx low 2 cycles after handshake, then 1,0,1,0,1,0,1,0, then stop high, each 4 cycles; total 40 cycles; o_msg_done stays 0.
REQ-033 Bytes 0x41,0x42,0x0A with tvalid held high, last byte tlast=1: three contiguous frames of 120 cycles with no idle gap; one o_msg_done pulse the cycle after the final stop bit.
REQ-034 tvalid held high with 6 bytes: o_tready drops after the FIFO fills (4 entries plus the byte popped into the shifter); it reasserts one cycle after each pop; all 6 bytes are transmitted in order.
REQ-035 i_rst_n pulled low during bit 3 of 0xA5 with 2 bytes queued: o_uart_tx=1 and o_tready=0 immediately; after release, line stays idle, o_busy=0, no o_msg_done.
REQ-036 Push and pop in the same cycle at occupancy 2: occupancy stays 2; the byte order is 0x01,0x02,0x03 on the line.
REQ-037 Byte 0xFF, tlast=1: line low for only the 4-cycle start bit, then high for 36 cycles; o_msg_done pulses once.
